// File: rtl/mp_seg_addsub.sv
// Segment-serial multi-precision add / sub / Montgomery add-reduce.
// One SEG-bit slice per cycle through a single registered-carry slice adder.
module mp_seg_addsub #(
    parameter int WIDTH = 514,
    parameter int SEG   = 103
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // state | meaning
    // IDLE  | waiting for start, operands captured on accept
    // PASS1 | slice-serial a + b (or a + ~b + 1)
    // PASS2 | slice-serial sum - m into diff (add-reduce only)
    // DONE  | one-cycle done pulse, result/cout final

    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int TOP  = WIDTH - (NSEG - 1) * SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0]  res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              sum_cout_q, sum_cout_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]           op_a, op_x, dst_old, new_vec;
    logic [NSEG-1:0][SEG-1:0]   a_2d, x_2d;
    logic [SEG-1:0]             sl_a, sl_x;
    logic [SEG:0]               sum;
    logic                       last, c_out, apply;

    always_comb begin
        if (state_q == S_PASS2) begin
            op_a    = res_q;
            op_x    = ~m_q;
            dst_old = diff_q;
        end else begin
            op_a    = a_q;
            op_x    = (mode_q == 2'b01) ? ~b_q : b_q;
            dst_old = res_q;
        end
    end

    // Bit-level scatter/gather keeps every index constant; the top slice
    // is zero-padded so only its valid bits enter the adder.
    for (genvar j = 0; j < WIDTH; j++) begin : gen_bit
        localparam int SI = j / SEG;
        localparam int BI = j % SEG;
        assign a_2d[SI][BI] = op_a[j];
        assign x_2d[SI][BI] = op_x[j];
        assign new_vec[j]   = (cnt_q == CW'(SI)) ? sum[BI] : dst_old[j];
    end
    if (TOP < SEG) begin : gen_pad
        for (genvar p = TOP; p < SEG; p++) begin : gen_pad_bit
            assign a_2d[NSEG-1][p] = 1'b0;
            assign x_2d[NSEG-1][p] = 1'b0;
        end
    end

    assign sl_a  = a_2d[cnt_q];
    assign sl_x  = x_2d[cnt_q];
    assign sum   = {1'b0, sl_a} + {1'b0, sl_x} + {{SEG{1'b0}}, carry_q};
    assign last  = (cnt_q == CW'(NSEG - 1));
    assign c_out = last ? sum[TOP] : sum[SEG];
    assign apply = sum_cout_q | c_out;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        a_d        = a_q;
        b_d        = b_q;
        m_d        = m_q;
        res_d      = res_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        sum_cout_d = sum_cout_q;
        cout_d     = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    mode_d  = (mode == 2'b11) ? 2'b00 : mode;
                    cnt_d   = '0;
                    carry_d = (mode == 2'b01);
                    state_d = S_PASS1;
                end
            end
            S_PASS1: begin
                res_d   = new_vec;
                carry_d = c_out;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    if (mode_q == 2'b10) begin
                        sum_cout_d = c_out;
                        carry_d    = 1'b1;
                        state_d    = S_PASS2;
                    end else begin
                        cout_d  = c_out;
                        state_d = S_DONE;
                    end
                end
            end
            S_PASS2: begin
                diff_d  = new_vec;
                carry_d = c_out;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    cout_d  = apply;
                    if (apply) res_d = new_vec;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            res_q      <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            sum_cout_q <= 1'b0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            b_q        <= b_d;
            m_q        <= m_d;
            res_q      <= res_d;
            diff_q     <= diff_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            sum_cout_q <= sum_cout_d;
            cout_q     <= cout_d;
        end
    end

    assign busy   = (state_q == S_PASS1) || (state_q == S_PASS2);
    assign done   = (state_q == S_DONE);
    assign result = res_q;
    assign cout   = cout_q;

endmodule
